// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit counter states,
// the BTB entry layout for the default geometry, and the allocation counter value.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    localparam int unsigned BP_DATA_WIDTH = 32;
    localparam int unsigned BP_ENTRIES    = 16;
    localparam int unsigned BP_IDX_W      = $clog2(BP_ENTRIES);
    localparam int unsigned BP_TAG_W      = BP_DATA_WIDTH - 2 - BP_IDX_W;

    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_W-1:0]      tag;
        logic [BP_DATA_WIDTH-1:0] target;
        bp_ctr_e                  ctr;
    } bp_entry_t;

    // A conditional branch seen taken for the first time starts weakly taken.
    localparam bp_ctr_e BP_INIT_ALLOC = WT;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter; jumps force
// strongly-taken.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  bp_ctr_e ctr_i,
    input  logic    taken_i,
    input  logic    force_st_i,
    output bp_ctr_e ctr_o
);

    // Saturating step toward the resolved direction
    always_comb begin
        ctr_o = ctr_i;
        if (force_st_i) begin
            ctr_o = ST;
        end else begin
            case (ctr_i)
                SNT:     ctr_o = taken_i ? WNT : SNT;
                WNT:     ctr_o = taken_i ? WT  : SNT;
                WT:      ctr_o = taken_i ? ST  : WNT;
                ST:      ctr_o = taken_i ? ST  : WT;
                default: ctr_o = BP_INIT_ALLOC;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup, execute
// training and mispredict detection. Optional BP_STATS_EN adds event counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ENTRIES    = 16,
    localparam int unsigned IDX_W     = $clog2(ENTRIES),
    localparam int unsigned TAG_W     = DATA_WIDTH - 2 - IDX_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] PCF_i,
    output logic                  PredictTakenF_o,
    output logic [DATA_WIDTH-1:0] PredictTargetF_o,
    input  logic                  ValidE_i,
    input  logic                  BranchE_i,
    input  logic                  JumpE_i,
    input  logic [DATA_WIDTH-1:0] PCE_i,
    input  logic                  PredictTakenE_i,
    input  logic [DATA_WIDTH-1:0] PredictTargetE_i,
    input  logic                  PCSrcE_i,
    input  logic [DATA_WIDTH-1:0] ActualTargetE_i,
    output logic                  MispredictE_o
`ifdef BP_STATS_EN
    ,
    output logic [31:0]           StatBranches_o,
    output logic [31:0]           StatMispredicts_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(3'd4);

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_q [ENTRIES];
    bp_ctr_e               ctr_q [ENTRIES];

    logic [IDX_W-1:0] idx_f_s, idx_e_s;
    logic [TAG_W-1:0] tag_f_s, tag_e_s;
    logic             hit_f_s, hit_e_s;
    bp_ctr_e          ctr_f_s, ctr_step_s, ctr_new_s;
    logic             resolve_s, tgt_we_s, ctr_we_s;
    logic             unused_pc_lsb_s;

    assign unused_pc_lsb_s = ^{PCF_i[1:0], PCE_i[1:0]};

    assign idx_f_s = PCF_i[IDX_W+1:2];
    assign tag_f_s = PCF_i[DATA_WIDTH-1:IDX_W+2];
    assign idx_e_s = PCE_i[IDX_W+1:2];
    assign tag_e_s = PCE_i[DATA_WIDTH-1:IDX_W+2];

    // Lookup reads current array contents, so a same-cycle write is not bypassed.
    assign ctr_f_s          = ctr_q[idx_f_s];
    assign hit_f_s          = valid_q[idx_f_s] & (tag_q[idx_f_s] == tag_f_s);
    assign PredictTakenF_o  = hit_f_s & ctr_f_s[1];
    assign PredictTargetF_o = hit_f_s ? tgt_q[idx_f_s] : (PCF_i + PC_STEP);

    assign resolve_s     = ValidE_i & (BranchE_i | JumpE_i);
    assign hit_e_s       = valid_q[idx_e_s] & (tag_q[idx_e_s] == tag_e_s);
    assign MispredictE_o = resolve_s &
                           ((PredictTakenE_i != PCSrcE_i) |
                            (PredictTakenE_i & PCSrcE_i & (PredictTargetE_i != ActualTargetE_i)));

    bp_sat_ctr u_sat_ctr (
        .ctr_i      (ctr_q[idx_e_s]),
        .taken_i    (PCSrcE_i),
        .force_st_i (JumpE_i),
        .ctr_o      (ctr_step_s)
    );

    // Taken resolutions write the target (and tag, a no-op on hit); misses allocate.
    always_comb begin
        tgt_we_s  = resolve_s & PCSrcE_i;
        ctr_we_s  = resolve_s & (hit_e_s | PCSrcE_i);
        ctr_new_s = ctr_step_s;
        valid_d   = valid_q;
        if (hit_e_s) begin
            ctr_new_s = ctr_step_s;
        end else if (JumpE_i) begin
            ctr_new_s = ST;
        end else begin
            ctr_new_s = BP_INIT_ALLOC;
        end
        if (tgt_we_s) begin
            valid_d[idx_e_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only state reset needs to clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Entry payload arrays; meaningless while the matching valid bit is clear
    always_ff @(posedge clk_i) begin
        if (tgt_we_s) begin
            tag_q[idx_e_s] <= tag_e_s;
            tgt_q[idx_e_s] <= ActualTargetE_i;
        end
        if (ctr_we_s) begin
            ctr_q[idx_e_s] <= ctr_new_s;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_mis_q;

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_br_q  <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            stat_br_q  <= resolve_s     ? (stat_br_q + 32'd1)  : stat_br_q;
            stat_mis_q <= MispredictE_o ? (stat_mis_q + 32'd1) : stat_mis_q;
        end
    end

    assign StatBranches_o    = stat_br_q;
    assign StatMispredicts_o = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic against an entry-level reference model. Honours BP_STATS_EN.
module tb_branch_predictor;
    import bp_pkg::*;

    localparam int N  = 16;
    localparam int IW = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] PCF_i;
    logic        PredictTakenF_o;
    logic [31:0] PredictTargetF_o;
    logic        ValidE_i, BranchE_i, JumpE_i, PredictTakenE_i, PCSrcE_i;
    logic [31:0] PCE_i, PredictTargetE_i, ActualTargetE_i;
    logic        MispredictE_o;
`ifdef BP_STATS_EN
    logic [31:0] StatBranches_o, StatMispredicts_o;
`endif

    int checks = 0;
    int errors = 0;

    bp_entry_t   m_btb [N];
    int          m_br  = 0;
    int          m_mis = 0;

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(N)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .PCF_i            (PCF_i),
        .PredictTakenF_o  (PredictTakenF_o),
        .PredictTargetF_o (PredictTargetF_o),
        .ValidE_i         (ValidE_i),
        .BranchE_i        (BranchE_i),
        .JumpE_i          (JumpE_i),
        .PCE_i            (PCE_i),
        .PredictTakenE_i  (PredictTakenE_i),
        .PredictTargetE_i (PredictTargetE_i),
        .PCSrcE_i         (PCSrcE_i),
        .ActualTargetE_i  (ActualTargetE_i),
        .MispredictE_o    (MispredictE_o)
`ifdef BP_STATS_EN
        ,
        .StatBranches_o   (StatBranches_o),
        .StatMispredicts_o(StatMispredicts_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % 32'(N));
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc >> (IW + 2);
    endfunction

    function automatic bit ref_hit(logic [31:0] pc);
        int i = idx_of(pc);
        return m_btb[i].valid && (32'(m_btb[i].tag) == tag_of(pc));
    endfunction

    function automatic bit ref_taken(logic [31:0] pc);
        return ref_hit(pc) && (m_btb[idx_of(pc)].ctr == WT || m_btb[idx_of(pc)].ctr == ST);
    endfunction

    function automatic logic [31:0] ref_target(logic [31:0] pc);
        if (ref_hit(pc)) return m_btb[idx_of(pc)].target;
        return pc + 32'd4;
    endfunction

    function automatic bit ref_resolve();
        return ValidE_i && (BranchE_i || JumpE_i);
    endfunction

    function automatic bit ref_mis();
        if (!ref_resolve()) return 1'b0;
        if (PredictTakenE_i != PCSrcE_i) return 1'b1;
        return PCSrcE_i && (PredictTargetE_i != ActualTargetE_i);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_btb[i].valid = 1'b0;
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic void model_train();
        int i;
        int c;
        if (!ref_resolve()) return;
        m_br++;
        if (ref_mis()) m_mis++;
        i = idx_of(PCE_i);
        if (ref_hit(PCE_i)) begin
            c = int'(m_btb[i].ctr);
            if (JumpE_i)       c = 3;
            else if (PCSrcE_i) c = (c == 3) ? 3 : c + 1;
            else               c = (c == 0) ? 0 : c - 1;
            m_btb[i].ctr = bp_ctr_e'(c[1:0]);
            if (PCSrcE_i) m_btb[i].target = ActualTargetE_i;
        end else if (PCSrcE_i) begin
            m_btb[i].valid  = 1'b1;
            m_btb[i].tag    = BP_TAG_W'(tag_of(PCE_i));
            m_btb[i].target = ActualTargetE_i;
            m_btb[i].ctr    = JumpE_i ? ST : WT;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_e(input logic v, input logic br, input logic jp, input logic [31:0] pce,
                           input logic ptk, input logic [31:0] ptg, input logic src,
                           input logic [31:0] act);
        ValidE_i = v; BranchE_i = br; JumpE_i = jp; PCE_i = pce;
        PredictTakenE_i = ptk; PredictTargetE_i = ptg; PCSrcE_i = src; ActualTargetE_i = act;
    endtask

    task automatic idle_e();
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        if (rst_ni) model_train();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        PCF_i  = 32'h100;
        drive_e(1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        model_reset();
        #2;
        checks++;
        if (PredictTakenF_o !== 1'b0) begin
            errors++; $display("FAIL reset_taken: got %b exp 0", PredictTakenF_o);
        end
        checks++;
        if (PredictTargetF_o !== 32'h104) begin
            errors++; $display("FAIL reset_target: got %h exp 00000104", PredictTargetF_o);
        end
        checks++;
        if (MispredictE_o !== 1'b0) begin
            errors++; $display("FAIL reset_nomis_invalid: got %b exp 0", MispredictE_o);
        end
        PCF_i = 32'hFFFF_FFFC;
        #1;
        checks++;
        if (PredictTargetF_o !== 32'h0) begin
            errors++; $display("FAIL wrap_target: got %h exp 00000000", PredictTargetF_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_basic();
        drive_e(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
        PCF_i = 32'h100;
        #1;
        checks++;
        if (MispredictE_o !== 1'b1) begin
            errors++; $display("FAIL basic_mis: got %b exp 1", MispredictE_o);
        end
        tick();
        idle_e();
        #1;
        checks++;
        if (PredictTakenF_o !== 1'b1 || PredictTargetF_o !== 32'h80) begin
            errors++; $display("FAIL basic_alloc: got %b/%h exp 1/00000080", PredictTakenF_o, PredictTargetF_o);
        end
    endtask

    task automatic test_ctr_walk();
        bit dirs [9] = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
        bit exps [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
        PCF_i = 32'h100;
        for (int k = 0; k < 9; k++) begin
            drive_e(1'b1, 1'b1, 1'b0, 32'h100, ref_taken(32'h100), ref_target(32'h100),
                    dirs[k], 32'h80);
            tick();
            idle_e();
            #1;
            checks++;
            if (PredictTakenF_o !== exps[k]) begin
                errors++; $display("FAIL ctr_walk step %0d: got %b exp %b", k, PredictTakenF_o, exps[k]);
            end
        end
    endtask

    task automatic test_jump();
        drive_e(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h204, 1'b1, 32'h300);
        tick();
        drive_e(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h340);
        #1;
        checks++;
        if (MispredictE_o !== 1'b1) begin
            errors++; $display("FAIL jalr_mis: got %b exp 1", MispredictE_o);
        end
        tick();
        idle_e();
        PCF_i = 32'h200;
        #1;
        checks++;
        if (PredictTakenF_o !== 1'b1 || PredictTargetF_o !== 32'h340) begin
            errors++; $display("FAIL jalr_update: got %b/%h exp 1/00000340", PredictTakenF_o, PredictTargetF_o);
        end
        drive_e(1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 32'h340, 1'b0, 32'h340);
        tick();
        idle_e();
        #1;
        checks++;
        if (PredictTakenF_o !== 1'b1) begin
            errors++; $display("FAIL jump_forced_st: got %b exp 1", PredictTakenF_o);
        end
    endtask

    task automatic test_alias();
        drive_e(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h104, 1'b1, 32'h500);
        tick();
        drive_e(1'b1, 1'b1, 1'b0, 32'h140, 1'b0, 32'h144, 1'b1, 32'h600);
        tick();
        idle_e();
        PCF_i = 32'h100;
        #1;
        checks++;
        if (PredictTakenF_o !== 1'b0 || PredictTargetF_o !== 32'h104) begin
            errors++; $display("FAIL alias_evicted: got %b/%h exp 0/00000104", PredictTakenF_o, PredictTargetF_o);
        end
        PCF_i = 32'h140;
        #1;
        checks++;
        if (PredictTakenF_o !== 1'b1 || PredictTargetF_o !== 32'h600) begin
            errors++; $display("FAIL alias_hit: got %b/%h exp 1/00000600", PredictTakenF_o, PredictTargetF_o);
        end
        drive_e(1'b1, 1'b1, 1'b0, 32'h140, 1'b1, 32'h600, 1'b1, 32'h700);
        #1;
        checks++;
        if (PredictTargetF_o !== 32'h600) begin
            errors++; $display("FAIL same_cycle_old: got %h exp 00000600", PredictTargetF_o);
        end
        tick();
        idle_e();
        #1;
        checks++;
        if (PredictTargetF_o !== 32'h700) begin
            errors++; $display("FAIL same_cycle_new: got %h exp 00000700", PredictTargetF_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] pce;
        logic [31:0] pool [12];
        for (int i = 0; i < 12; i++)
            pool[i] = 32'h1000 + 32'((i % 3) * 64) + 32'((i / 3) * 4);
        for (int n = 0; n < 400; n++) begin
            pce = pool[$urandom_range(0, 11)] | 32'($urandom_range(0, 3));
            PCF_i = pool[$urandom_range(0, 11)] | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                drive_e($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                        pce, ref_taken(pce), ref_target(pce), $urandom_range(0, 1) == 1,
                        {20'h0, 4'($urandom_range(1, 3)), 8'($urandom_range(0, 255)) & 8'hFC});
            else
                drive_e($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                        pce, $urandom_range(0, 1) == 1, ref_target(pce), $urandom_range(0, 1) == 1,
                        ref_target(pce));
            #1;
            checks++;
            if (PredictTakenF_o !== ref_taken(PCF_i)) begin
                errors++; $display("FAIL rnd_taken n=%0d pc=%h: got %b exp %b", n, PCF_i, PredictTakenF_o, ref_taken(PCF_i));
            end
            checks++;
            if (PredictTargetF_o !== ref_target(PCF_i)) begin
                errors++; $display("FAIL rnd_target n=%0d pc=%h: got %h exp %h", n, PCF_i, PredictTargetF_o, ref_target(PCF_i));
            end
            checks++;
            if (MispredictE_o !== ref_mis()) begin
                errors++; $display("FAIL rnd_mis n=%0d: got %b exp %b", n, MispredictE_o, ref_mis());
            end
            tick();
        end
        idle_e();
`ifdef BP_STATS_EN
        #1;
        checks++;
        if (StatBranches_o !== 32'(m_br) || StatMispredicts_o !== 32'(m_mis)) begin
            errors++; $display("FAIL stats_count: got %0d/%0d exp %0d/%0d", StatBranches_o, StatMispredicts_o, m_br, m_mis);
        end
`endif
    endtask

    task automatic test_reset_mid();
        drive_e(1'b1, 1'b1, 1'b0, 32'h2000, 1'b0, 32'h2004, 1'b1, 32'h3000);
        tick();
        idle_e();
        PCF_i = 32'h2000;
        #1;
        checks++;
        if (PredictTakenF_o !== 1'b1) begin
            errors++; $display("FAIL pre_reset_hit: got %b exp 1", PredictTakenF_o);
        end
        drive_e(1'b1, 1'b1, 1'b0, 32'h2010, 1'b0, 32'h2014, 1'b1, 32'h3100);
        rst_ni = 1'b0;
        model_reset();
        #1;
        checks++;
        if (PredictTakenF_o !== 1'b0 || PredictTargetF_o !== 32'h2004) begin
            errors++; $display("FAIL async_reset_miss: got %b/%h exp 0/00002004", PredictTakenF_o, PredictTargetF_o);
        end
`ifdef BP_STATS_EN
        checks++;
        if (StatBranches_o !== 32'd0 || StatMispredicts_o !== 32'd0) begin
            errors++; $display("FAIL stats_reset: got %0d/%0d exp 0/0", StatBranches_o, StatMispredicts_o);
        end
`endif
        tick();
        idle_e();
        rst_ni = 1'b1;
        PCF_i  = 32'h2010;
        #1;
        checks++;
        if (PredictTakenF_o !== 1'b0 || PredictTargetF_o !== 32'h2014) begin
            errors++; $display("FAIL write_during_reset_lost: got %b/%h exp 0/00002014", PredictTakenF_o, PredictTargetF_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ctr_walk();
        test_jump();
        test_alias();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
